dsi_pixel_packer: RTL and testbench
===================================

Name: dsi_pixel_packer

Overview:
- Upstream feeder for the DSI transmitter's pixel interface, in the clk_pixel domain.
- Takes the 720p30 video stream at one RGB888 pixel per clock, as de/hs/vs plus 24-bit data.
- Pairs pixels into the 64-bit pixel_data word (two pixels per word), and generates pixel_data_valid, haddr, hsync, vsync, datatype and vc.
- Frame-aligns on vsync and flags lines whose active width differs from H_ACTIVE.

Parameters:
- H_ACTIVE, 1280, expected active pixels per line; used for the line-length check.
- HS_POL, 1, input hsync polarity (1 = active-high).
- VS_POL, 1, input vsync polarity (1 = active-high).
- DATATYPE, 6'h3E, DSI data type driven on datatype (packed RGB888).
- VC, 2'd0, DSI virtual channel driven on vc.

Ports:
- clk_pixel  in  1  pixel clock.
- reset_pixel  in  1  asynchronous, active-high reset.
- vid_de  in  1  active-video enable.
- vid_hs  in  1  hsync, polarity set by HS_POL.
- vid_vs  in  1  vsync, polarity set by VS_POL.
- vid_rgb  in  24  pixel, {R,G,B}.
- err_clr  in  1  clears line_err.
- pixel_data_valid  out  1  word valid, one-cycle pulse.
- pixel_data  out  64  {16'h0, pixel1, pixel0}.
- haddr  out  16  pixel index of pixel0 within the line.
- hsync  out  1  active-high hsync, pipeline-aligned.
- vsync  out  1  active-high vsync, pipeline-aligned.
- datatype  out  6  constant DATATYPE.
- vc  out  2  constant VC.
- line_err  out  1  sticky line-width mismatch flag.

Behaviour:
- Single clock. Reset is asynchronous and active-high.
- Reset values:
  - All outputs 0, except datatype = DATATYPE and vc = VC (driven continuously).
  - FSM in WAIT_VS, pixel counter 0, holding register 0.
- Stage 0 registers the inputs and normalises polarity: hs_n = vid_hs ^ ~HS_POL, and likewise for vs.
- Stage 1 is the output register. hsync and vsync are stage-0 values delayed one more cycle, so data and syncs have an equal 2-cycle latency.
- FSM states:
  - WAIT_VS: ignore de. On a rising edge of normalised vs → IDLE. This is frame alignment after reset, so no partial frame is emitted.
  - IDLE: on de=1, load the pixel into hold, set haddr_next = pix_cnt, pix_cnt++, → HOLD.
  - HOLD:
    - de=1: emit {16'h0, cur, hold}, valid=1, haddr = index of the held pixel, pix_cnt++, → IDLE.
    - de=0 (odd-width line end): emit {16'h0, 24'h0, hold}, valid=1, → IDLE.
- Pixel counter is 16 bits and clears on every rising edge of de. It saturates at 16'hFFFF and does not wrap.
- Line check, on each falling edge of de (stage 0): if pix_cnt != H_ACTIVE, set line_err.
- line_err stays set until err_clr. If err_clr and a new mismatch occur in the same cycle, the set wins.
- Output word latency:
  - Word for pixels (2k, 2k+1) has valid asserted 2 cycles after pixel 2k+1 is presented.
  - Odd-flush word appears 2 cycles after the de-low cycle that follows the last pixel.
- pixel_data holds its last value when valid=0. Downstream samples only on valid.
- No back-pressure: the DSI transmitter must accept every valid word.
- vs edge during HOLD (malformed input): flush the held pixel as in the odd case, then continue normally.
- Reset asserted mid-line: immediate return to reset values. After release, the block waits for the next vs rising edge.

Decomposition:
- Shared package dsi_pkg:
  - DT_RGB888 = 6'h3E, DT_RGB565 = 6'h0E.
  - PIXEL_W = 24, WORD_W = 64.
  - Packer state enum {WAIT_VS, IDLE, HOLD}.
- No sub-module needed. The edge detector (de/vs rising and falling) is a small inline always block; it is not worth a separate module.

Test Plan:
- Reset, then 2 frames of 1280-pixel lines, vid_rgb = pixel index → 640 valid pulses per line; word k = {16'h0, 24'(2k+1), 24'(2k)}, haddr = 2k; line_err stays 0.
- De pulses before the first vs edge after reset → no pixel_data_valid; the first word appears only after the vs rising edge.
- 5-pixel line with values 1..5 → 3 words: {0,2,1} haddr 0, {0,4,3} haddr 2, {0,0,5} haddr 4; line_err = 1.
- line_err set, then err_clr pulsed in the same cycle as a new mismatching de fall → line_err remains 1; err_clr alone on the next cycle clears it to 0.
- HS_POL = 0, VS_POL = 0 with active-low input syncs → hsync and vsync are active-high, delayed exactly 2 cycles from vid_hs/vid_vs.
- Reset pulsed in the middle of line 3 → all outputs 0 within the reset cycle; the next valid word only after a vs edge, with haddr starting at 0.

Source files
------------

// File: rtl/dsi_pkg.sv
// Shared DSI definitions: data types, bus widths and the pixel-packer state
// encoding, plus a saturating counter helper.
package dsi_pkg;

  localparam logic [5:0] DT_RGB888 = 6'h3E;
  localparam logic [5:0] DT_RGB565 = 6'h0E;

  localparam int PIXEL_W = 24;
  localparam int WORD_W  = 64;

  typedef enum logic [1:0] {
    WAIT_VS,
    IDLE,
    HOLD
  } pack_state_t;

  // Pixel index stops at all-ones instead of wrapping on absurdly long lines.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dsi_pixel_packer.sv
// Pairs a one-pixel-per-clock RGB888 video stream into 64-bit DSI pixel words,
// frame-aligned on vsync, with a sticky flag for lines of unexpected width.
module dsi_pixel_packer
  import dsi_pkg::*;
#(
  parameter int          H_ACTIVE = 1280,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter logic [5:0]  DATATYPE = DT_RGB888,
  parameter logic [1:0]  VC       = 2'd0
) (
  input  logic               clk_pixel,
  input  logic               reset_pixel,
  input  logic               vid_de,
  input  logic               vid_hs,
  input  logic               vid_vs,
  input  logic [PIXEL_W-1:0] vid_rgb,
  input  logic               err_clr,
  output logic               pixel_data_valid,
  output logic [WORD_W-1:0]  pixel_data,
  output logic [15:0]        haddr,
  output logic               hsync,
  output logic               vsync,
  output logic [5:0]         datatype,
  output logic [1:0]         vc,
  output logic               line_err
);

  assign datatype = DATATYPE;
  assign vc       = VC;

  // Stage 0: input register with sync polarity normalised to active-high,
  // plus one-cycle-old copies of de/vs for edge detection.
  logic               de_s0, hs_s0, vs_s0;
  logic [PIXEL_W-1:0] rgb_s0;
  logic               de_p, vs_p;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk_pixel or posedge reset_pixel) begin
    if (reset_pixel) begin
      de_s0  <= 1'b0;
      hs_s0  <= 1'b0;
      vs_s0  <= 1'b0;
      rgb_s0 <= '0;
      de_p   <= 1'b0;
      vs_p   <= 1'b0;
    end else begin
      de_s0  <= vid_de;
      hs_s0  <= vid_hs ^ ~HS_POL;
      vs_s0  <= vid_vs ^ ~VS_POL;
      rgb_s0 <= vid_rgb;
      de_p   <= de_s0;
      vs_p   <= vs_s0;
    end
  end

  logic de_rise, de_fall, vs_rise;
  assign de_rise = de_s0 & ~de_p;
  assign de_fall = ~de_s0 & de_p;
  assign vs_rise = vs_s0 & ~vs_p;

  pack_state_t        state, state_d;
  logic [15:0]        pix_cnt, cnt_d, cnt_base;
  logic [PIXEL_W-1:0] hold, hold_d;
  logic [15:0]        haddr_next, haddr_next_d;
  logic               emit;
  logic [WORD_W-1:0]  emit_data;
  logic               mismatch;

  // The first pixel of a line is indexed from zero even though pix_cnt still
  // holds the previous line's count in that cycle.
  assign cnt_base = de_rise ? 16'd0 : pix_cnt;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt_base;
    hold_d       = hold;
    haddr_next_d = haddr_next;
    emit         = 1'b0;
    emit_data    = '0;
    unique case (state)
      WAIT_VS: begin
        if (vs_rise) state_d = IDLE;
      end
      IDLE: begin
        if (de_s0) begin
          hold_d       = rgb_s0;
          haddr_next_d = cnt_base;
          cnt_d        = sat_inc(cnt_base);
          state_d      = HOLD;
        end
      end
      HOLD: begin
        emit    = 1'b1;
        state_d = IDLE;
        if (de_s0 && !vs_rise) begin
          emit_data = {16'h0, rgb_s0, hold};
          cnt_d     = sat_inc(cnt_base);
        end else begin
          // Line ended on an odd pixel, or a stray vsync: flush the lone pixel.
          emit_data = {16'h0, 24'h0, hold};
          if (de_s0) begin
            hold_d       = rgb_s0;
            haddr_next_d = cnt_base;
            cnt_d        = sat_inc(cnt_base);
            state_d      = HOLD;
          end
        end
      end
      default: state_d = WAIT_VS;
    endcase
  end

  // Lines that ended before frame alignment are not judged.
  assign mismatch = de_fall && (state != WAIT_VS) && (pix_cnt != 16'(H_ACTIVE));

  // NOTE: every register here, the pixel hold included, is a plain flop with
  // a defined reset value; nothing is left to power-up state.
  always_ff @(posedge clk_pixel or posedge reset_pixel) begin
    if (reset_pixel) begin
      state      <= WAIT_VS;
      pix_cnt    <= '0;
      hold       <= '0;
      haddr_next <= '0;
    end else begin
      state      <= state_d;
      pix_cnt    <= cnt_d;
      hold       <= hold_d;
      haddr_next <= haddr_next_d;
    end
  end

  // Stage 1: output register; syncs travel alongside the data.
  always_ff @(posedge clk_pixel or posedge reset_pixel) begin
    if (reset_pixel) begin
      pixel_data_valid <= 1'b0;
      pixel_data       <= '0;
      haddr            <= '0;
      hsync            <= 1'b0;
      vsync            <= 1'b0;
      line_err         <= 1'b0;
    end else begin
      pixel_data_valid <= emit;
      if (emit) begin
        pixel_data <= emit_data;
        haddr      <= haddr_next;
      end
      hsync <= hs_s0;
      vsync <= vs_s0;
      if (mismatch)     line_err <= 1'b1;
      else if (err_clr) line_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dsi_pixel_packer.sv
// Self-checking bench for dsi_pixel_packer: directed frames plus random lines,
// checked cycle by cycle against a line-level reference model.
module tb_dsi_pixel_packer;
  import dsi_pkg::*;

  localparam int H_ACT = 1280;

  logic        clk_pixel = 1'b0;
  logic        reset_pixel = 1'b1;
  logic        vid_de = 1'b0, vid_hs = 1'b0, vid_vs = 1'b0;
  logic [23:0] vid_rgb = '0;
  logic        err_clr = 1'b0;
  logic        vid_hs_n, vid_vs_n;

  assign vid_hs_n = ~vid_hs;
  assign vid_vs_n = ~vid_vs;

  logic        a_valid, a_hsync, a_vsync, a_line_err;
  logic [63:0] a_data;
  logic [15:0] a_haddr;
  logic [5:0]  a_dt;
  logic [1:0]  a_vc;
  logic        b_valid, b_hsync, b_vsync, b_line_err;
  logic [63:0] b_data;
  logic [15:0] b_haddr;
  logic [5:0]  b_dt;
  logic [1:0]  b_vc;

  always #5 clk_pixel = ~clk_pixel;

  dsi_pixel_packer #(.H_ACTIVE(H_ACT)) u_pos (
    .clk_pixel(clk_pixel), .reset_pixel(reset_pixel),
    .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_rgb(vid_rgb),
    .err_clr(err_clr), .pixel_data_valid(a_valid), .pixel_data(a_data),
    .haddr(a_haddr), .hsync(a_hsync), .vsync(a_vsync), .datatype(a_dt),
    .vc(a_vc), .line_err(a_line_err)
  );

  dsi_pixel_packer #(.H_ACTIVE(H_ACT), .HS_POL(1'b0), .VS_POL(1'b0)) u_neg (
    .clk_pixel(clk_pixel), .reset_pixel(reset_pixel),
    .vid_de(vid_de), .vid_hs(vid_hs_n), .vid_vs(vid_vs_n), .vid_rgb(vid_rgb),
    .err_clr(err_clr), .pixel_data_valid(b_valid), .pixel_data(b_data),
    .haddr(b_haddr), .hsync(b_hsync), .vsync(b_vsync), .datatype(b_dt),
    .vc(b_vc), .line_err(b_line_err)
  );

  typedef struct {
    logic [63:0] data;
    logic [15:0] addr;
    int          e;
  } word_t;

  word_t       exp_q[$];
  logic [23:0] line_q[$];
  int          edge_cnt = 0;
  logic [7:0]  hs_hist = '0, vs_hist = '0;
  bit          aligned, prev_de, prev_vs, m_err, pend_mis;
  int          n_checks = 0, n_fail = 0;
  int          n_valid = 0;
  bit          first_seen;
  logic [15:0] first_haddr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void push_word(input logic [63:0] d, input logic [15:0] a);
    exp_q.push_back('{data: d, addr: a, e: edge_cnt + 1});
  endfunction

  task automatic model_reset();
    exp_q.delete();
    line_q.delete();
    aligned    = 1'b0;
    prev_de    = 1'b0;
    prev_vs    = 1'b0;
    m_err      = 1'b0;
    pend_mis   = 1'b0;
    first_seen = 1'b0;
  endtask

  // One input cycle; hs/vs are given active-high. The model records what each
  // clock edge must produce: words two cycles after the completing pixel,
  // syncs two cycles after sampling, and the line-width flag.
  task automatic cyc(input bit de, input bit hs, input bit vs,
                     input logic [23:0] rgb, input bit clr = 1'b0);
    int idx;
    vid_de  = de;
    vid_hs  = hs;
    vid_vs  = vs;
    vid_rgb = rgb;
    err_clr = clr;
    @(posedge clk_pixel);
    edge_cnt++;
    idx = edge_cnt % 8;
    if (reset_pixel) begin
      hs_hist[idx] = 1'b0;
      vs_hist[idx] = 1'b0;
    end else begin
      hs_hist[idx] = hs;
      vs_hist[idx] = vs;
      if (pend_mis)  m_err = 1'b1;
      else if (clr)  m_err = 1'b0;
      pend_mis = 1'b0;
      if (aligned) begin
        if (!de && prev_de) begin
          if (line_q.size() % 2 == 1)
            push_word({40'h0, line_q[$]}, 16'(line_q.size() - 1));
          if (line_q.size() != H_ACT) pend_mis = 1'b1;
        end
        if (de) begin
          if (!prev_de) line_q.delete();
          line_q.push_back(rgb);
          if (line_q.size() % 2 == 0)
            push_word({16'h0, line_q[$], line_q[$-1]}, 16'(line_q.size() - 2));
        end
      end else if (vs && !prev_vs) begin
        aligned = 1'b1;
      end
      prev_de = de;
      prev_vs = vs;
    end
    #1;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic hpulse();
    blank(2);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 24'h0);
    blank(3);
  endtask

  task automatic vpulse();
    blank(2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 24'h0);
    blank(3);
  endtask

  task automatic line_idx(input int n);
    hpulse();
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 24'(i));
    blank(1);
  endtask

  task automatic line_rand(input int n);
    hpulse();
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 24'($urandom));
    blank(1);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk_pixel) begin
    int    pi;
    bit    exp_v;
    word_t w;
    if (!reset_pixel && edge_cnt > 0) begin
      pi    = (edge_cnt + 7) % 8;
      exp_v = (exp_q.size() > 0) && (exp_q[0].e == edge_cnt);
      check("valid", a_valid, exp_v);
      check("valid_neg_pol", b_valid, exp_v);
      if (a_valid) begin
        n_valid++;
        if (!first_seen) begin
          first_seen  = 1'b1;
          first_haddr = a_haddr;
        end
      end
      if (exp_v) begin
        w = exp_q.pop_front();
        check("pixel_data", a_data, w.data);
        check("haddr", a_haddr, w.addr);
      end
      check("hsync", a_hsync, hs_hist[pi]);
      check("vsync", a_vsync, vs_hist[pi]);
      check("hsync_neg_pol", b_hsync, hs_hist[pi]);
      check("vsync_neg_pol", b_vsync, vs_hist[pi]);
      check("line_err", a_line_err, m_err);
    end
  end

  initial begin
    int base;
    model_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 24'h0);
    check("rst_valid", a_valid, 1'b0);
    check("rst_data", a_data, 64'h0);
    check("rst_haddr", a_haddr, 16'h0);
    check("rst_hsync", a_hsync, 1'b0);
    check("rst_vsync", a_vsync, 1'b0);
    check("rst_line_err", a_line_err, 1'b0);
    check("datatype", a_dt, 6'h3E);
    check("vc", a_vc, 2'd0);
    check("datatype_neg_pol", b_dt, 6'h3E);
    check("vc_neg_pol", b_vc, 2'd0);
    reset_pixel = 1'b0;

    // Active lines before any vsync edge must produce nothing.
    blank(4);
    line_rand(6);
    line_rand(5);
    hpulse();
    check("pre_vs_words", n_valid, 0);

    // Two frames of full-width lines carrying the pixel index.
    base = n_valid;
    for (int f = 0; f < 2; f++) begin
      vpulse();
      for (int l = 0; l < 3; l++) line_idx(H_ACT);
      hpulse();
    end
    check("frame_words", n_valid - base, 2 * 3 * (H_ACT / 2));
    check("frame_line_err", a_line_err, 1'b0);

    // Short odd line 1..5: two pairs and one flushed pixel.
    base = n_valid;
    hpulse();
    for (int v = 1; v <= 5; v++) cyc(1'b1, 1'b0, 1'b0, 24'(v));
    blank(4);
    check("short_words", n_valid - base, 3);
    check("short_last_word", a_data, {16'h0, 24'h0, 24'd5});
    check("short_last_haddr", a_haddr, 16'd4);
    check("short_line_err", a_line_err, 1'b1);

    // err_clr coinciding with a new mismatch: the set wins.
    hpulse();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 24'($urandom));
    cyc(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 24'h0, 1'b1);
    blank(2);
    check("clr_vs_set", a_line_err, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 24'h0, 1'b1);
    check("clr_alone", a_line_err, 1'b0);

    // Random short lines with random gaps and sporadic err_clr.
    for (int l = 0; l < 8; l++) begin
      hpulse();
      for (int i = 0, n = $urandom_range(1, 9); i < n; i++)
        cyc(1'b1, 1'b0, 1'b0, 24'($urandom));
      for (int i = 0, g = $urandom_range(1, 6); i < g; i++)
        cyc(1'b0, 1'b0, 1'b0, 24'h0, ($urandom_range(0, 3) == 0));
    end
    blank(4);

    // Reset in the middle of line 3 of a new frame.
    vpulse();
    line_idx(H_ACT);
    line_idx(H_ACT);
    hpulse();
    for (int i = 0; i < 600; i++) cyc(1'b1, 1'b0, 1'b0, 24'($urandom));
    reset_pixel = 1'b1;
    model_reset();
    #1;
    check("midrst_valid", a_valid, 1'b0);
    check("midrst_data", a_data, 64'h0);
    check("midrst_haddr", a_haddr, 16'h0);
    check("midrst_hsync", a_hsync, 1'b0);
    check("midrst_vsync", a_vsync, 1'b0);
    check("midrst_line_err", a_line_err, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 24'($urandom));
    reset_pixel = 1'b0;
    base = n_valid;
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 1'b0, 24'($urandom));
    blank(1);
    line_rand(7);
    hpulse();
    check("post_rst_no_words", n_valid - base, 0);
    vpulse();
    line_rand(8);
    blank(4);
    check("post_rst_words", n_valid - base, 4);
    check("post_rst_seen", first_seen, 1'b1);
    check("post_rst_haddr0", first_haddr, 16'h0);

    blank(10);
    check("drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
